bus68k_arbiter: RTL
===================

# bus68k_arbiter

Parametrised N-master arbiter that multiplexes several 68k-style bus masters (CPU, DMA, video fetch, CD sector loader) onto one shared slave port. It has two selectable arbitration modes and a per-cycle timeout that terminates hung accesses with a bus-error pulse. It sits between the masters and the memory/peripheral decode, using the same AS/UDS/LDS/write_strobe/bus_ack signalling as the existing 68k bus.

## Interface
- NUM_MASTERS, 2: number of master ports (2..8).
- MODE, 0: 0 = fixed priority (lowest index wins); 1 = round robin.
- TIMEOUT_CYCLES, 1023: cycles in GRANT without bus_ack before bus error; 0 disables the timeout.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- m_as  in  NUM_MASTERS  per-master address strobe.
- m_write_strobe, m_uds, m_lds  in  NUM_MASTERS each  per-master cycle qualifiers.
- m_addr  in  NUM_MASTERS x 23  word address, bits [23:1].
- m_data_out  in  NUM_MASTERS x 16  master write data.
- m_bus_ack  out  NUM_MASTERS  acknowledge, routed to the granted master only.
- m_berr  out  NUM_MASTERS  one-cycle bus-error pulse on timeout.
- m_data_in  out  16  slave read data, broadcast to all masters; valid only with m_bus_ack.
- s_as, s_write_strobe, s_uds, s_lds  out  1 each  slave-side qualifiers.
- s_addr  out  23  slave address.
- s_data_out  out  16  slave write data.
- s_bus_ack  in  1  slave acknowledge.
- s_data_in  in  16  slave read data.
- grant  out  NUM_MASTERS  one-hot current owner; all zero when idle.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: if any m_as is high, pick a winner, register grant, and go to GRANT.
- Fixed mode: the lowest set index wins.
- Round robin: search starts at last_winner+1 and wraps modulo NUM_MASTERS. last_winner updates on each grant.
- GRANT: s_* signals mux from the granted master; s_as = m_as[g].
  - s_bus_ack high: m_bus_ack[g] = 1 in the same cycle (combinational). Next state is RELEASE.
  - Timeout counter reaches TIMEOUT_CYCLES: m_berr[g] pulses for 1 cycle, s_as is forced low, next state is RELEASE.
  - Granted master drops m_as before ack (abort): go to IDLE directly.
- RELEASE: s_as = 0 and grant is held. When m_as[g] is low, go to IDLE.
- Non-granted masters never see ack or berr. Their requests wait, and arbiter state holds no request history.
- Simultaneous s_bus_ack and timeout in the same cycle: ack wins, and no berr is raised.
- The timeout counter is 10 bits wide (width = clog2(TIMEOUT_CYCLES+1)). It clears on entry to GRANT and saturates, never wrapping.

## Timing
- Request seen in IDLE at cycle T: grant and s_as are high at T+1, so arbitration latency is 1 cycle.
- After an ack, the earliest next grant is 2 cycles after m_as falls: RELEASE→IDLE takes 1 cycle, then IDLE→GRANT takes 1 cycle.
- The ack and read data path is combinational from s_* to m_*, so it adds no latency.
- Reset values: state IDLE, grant 0, s_as/s_write_strobe/s_uds/s_lds 0, s_addr 0, s_data_out 0, m_bus_ack 0, m_berr 0, counter 0, last_winner NUM_MASTERS-1 so master 0 is first in round robin.
- Reset mid-cycle: s_as drops in the next cycle. No ack or berr is delivered to the interrupted master.

## Structure
- Shared package bus68k_pkg holds:
  - the arb_state_e enum (IDLE, GRANT, RELEASE);
  - MODE_FIXED/MODE_RR constants;
  - the ADDR_W=23 and DATA_W=16 constants.
- One sub-module, bus68k_rr_pick: combinational picker taking a request vector and a start index, returning a one-hot grant. Fixed mode uses start index 0.

## Test plan
- Fixed mode, N=3, masters 1 and 2 request together -> grant=3'b010 at T+1; master 2 is granted after master 1 releases.
- Round robin, N=4, all request continuously -> grant order 0,1,2,3,0, with each grant following a one-cycle ack.
- Slave never acks, TIMEOUT_CYCLES=16 -> m_berr[g] pulses exactly at GRANT cycle 16; s_as is low the next cycle; no m_bus_ack.
- Ack and timeout in the same cycle -> m_bus_ack=1, m_berr=0.
- Master drops m_as before ack -> state is IDLE the next cycle, and a pending master is granted the cycle after.
- reset asserted during GRANT with a read pending -> all outputs 0 the next cycle; the first grant after reset goes to master 0.

Source files
------------

// File: rtl/bus68k_pkg.sv
// bus68k_pkg: shared state type and bus widths
// for the multi-master 68k bus arbiter.
package bus68k_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

endpackage

// File: rtl/bus68k_rr_pick.sv
// bus68k_rr_pick: first set request at or after
// start, wrapping modulo N; one-hot result.
module bus68k_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         grant
);

  localparam int IW = $clog2(N);

  logic [IW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, start} + (IW+1)'(i);
      if (idx >= (IW+1)'(N))
        idx = idx - (IW+1)'(N);
      if (!found && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus68k_arbiter.sv
// bus68k_arbiter: N-master 68k bus arbiter with fixed or
// round-robin selection and a bus-error timeout.
module bus68k_arbiter
  import bus68k_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_MASTERS-1:0]             m_as,
  input  logic [NUM_MASTERS-1:0]             m_write_strobe,
  input  logic [NUM_MASTERS-1:0]             m_uds,
  input  logic [NUM_MASTERS-1:0]             m_lds,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_data_out,
  output logic [NUM_MASTERS-1:0]             m_bus_ack,
  output logic [NUM_MASTERS-1:0]             m_berr,
  output logic [DATA_W-1:0]                  m_data_in,
  output logic                               s_as,
  output logic                               s_write_strobe,
  output logic                               s_uds,
  output logic                               s_lds,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_data_out,
  input  logic                               s_bus_ack,
  input  logic [DATA_W-1:0]                  s_data_in,
  output logic [NUM_MASTERS-1:0]             grant
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          rr_start;
  logic [IW-1:0]          start;
  logic                   g_as;
  logic                   tmo;
  logic                   in_grant;
  logic                   active;

  assign rr_start = (last_q == IW'(NUM_MASTERS - 1)) ?
                    '0 : last_q + 1'b1;
  assign start    = (MODE == MODE_RR) ? rr_start : '0;

  bus68k_rr_pick #(
    .N(NUM_MASTERS)
  ) u_pick (
    .req  (m_as),
    .start(start),
    .grant(pick_grant)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (pick_grant[i]) pick_idx = IW'(i);
  end

  // last_q doubles as the index of the current owner
  assign g_as     = m_as[last_q];
  assign tmo      = (TIMEOUT_CYCLES != 0) && (cnt_q == CMAX);
  assign in_grant = (state_q == GRANT);
  assign active   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|m_as) begin
          state_d = GRANT;
          grant_d = pick_grant;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
        if (s_bus_ack || tmo) begin
          state_d = RELEASE;
        end else if (!g_as) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      RELEASE: begin
        if (!g_as) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign m_data_in = s_data_in;

  // an interrupted owner must not see a late ack or berr
  assign m_bus_ack = (in_grant && s_bus_ack && !reset) ?
                     grant_q : '0;
  assign m_berr    = (in_grant && tmo && !s_bus_ack && !reset) ?
                     grant_q : '0;

  assign s_as           = in_grant && g_as && !tmo;
  assign s_write_strobe = active && m_write_strobe[last_q];
  assign s_uds          = active && m_uds[last_q];
  assign s_lds          = active && m_lds[last_q];
  assign s_addr         = active ? m_addr[last_q] : '0;
  assign s_data_out     = active ? m_data_out[last_q] : '0;

endmodule
